// File: rtl/addr_mode1_operand_seq_if.sv
// Operand-sequencer bus bundle: upstream decode handshake, shared RF read port,
// and downstream shifter/ALU handoff.
//   master : the sequencer (drives in_ready, rf_ren/rf_raddr, out_valid and payload)
//   slave  : the environment (decode, register file, shifter/ALU stage)
interface addr_mode1_operand_seq_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned FLW  = 8;
  localparam int unsigned RAW  = 4;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_IR;
  logic [FLW-1:0]  in_flags;

  logic            rf_ren;
  logic [RAW-1:0]  rf_raddr;
  logic            rf_gnt;
  logic [XLEN-1:0] rf_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] sh_IR;
  logic [FLW-1:0]  sh_flags;
  logic [XLEN-1:0] sh_Rm_data;
  logic [7:0]      sh_Rs_LSB;
  logic [XLEN-1:0] out_Rn_data;

  modport master (
    input  in_valid, in_IR, in_flags, rf_gnt, rf_rdata, out_ready,
    output in_ready, rf_ren, rf_raddr, out_valid,
           sh_IR, sh_flags, sh_Rm_data, sh_Rs_LSB, out_Rn_data
  );

  modport slave (
    output in_valid, in_IR, in_flags, rf_gnt, rf_rdata, out_ready,
    input  in_ready, rf_ren, rf_raddr, out_valid,
           sh_IR, sh_flags, sh_Rm_data, sh_Rs_LSB, out_Rn_data
  );
endinterface

// File: rtl/addr_mode1_operand_seq.sv
// Operand fetch sequencer for the addressing-mode-1 / load-store shifter stage.
// Accepts one decoded instruction, reads Rn -> Rm -> Rs (only those needed)
// over a single shared RF read port, then hands IR/flags/Rm/Rs[7:0] to the
// shifter and Rn to the ALU stage.
// Ports:
//   clk    : clock, all state on rising edge
//   rst    : synchronous active-high reset
//   flush  : synchronous abort of the in-flight instruction
//   bus    : addr_mode1_operand_seq_if.master (decode in, RF port, operand out)
module addr_mode1_operand_seq #(
  parameter bit SKIP_RN_MOV = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  addr_mode1_operand_seq_if.master   bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned FLW  = 8;
  localparam int unsigned RAW  = 4;

  typedef enum logic [2:0] {S_IDLE, S_RN, S_RM, S_RS, S_DRAIN, S_OUT} state_t;
  typedef enum logic [1:0] {P_NONE, P_RN, P_RM, P_RS} pend_t;

  state_t          r_state, w_state_nxt;
  pend_t           r_pend,  w_pend_nxt;
  logic            r_out_valid;
  logic            r_rf_ren;
  logic [RAW-1:0]  r_rf_raddr;
  logic [XLEN-1:0] r_sh_IR;
  logic [FLW-1:0]  r_sh_flags;
  logic [XLEN-1:0] r_sh_Rm_data;
  logic [7:0]      r_sh_Rs_LSB;
  logic [XLEN-1:0] r_out_Rn_data;

  logic            w_accept;
  logic [3:0]      w_opc;
  logic [RAW-1:0]  w_rn_addr, w_rm_addr, w_rs_addr;
  logic [5:0]      w_cls;
  logic            w_is_dp, w_is_mov;
  logic            w_need_rn, w_need_rm, w_need_rs;
  logic            w_ren_nxt;
  logic [RAW-1:0]  w_raddr_nxt;

  assign bus.in_ready = (r_state == S_IDLE) && !rst && !flush;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Instruction fields come straight from the input in the accept cycle, else from the latched copy.
  assign w_opc     = w_accept ? bus.in_IR[24:21] : r_sh_IR[24:21];
  assign w_rn_addr = w_accept ? bus.in_IR[19:16] : r_sh_IR[19:16];
  assign w_rm_addr = w_accept ? bus.in_IR[3:0]   : r_sh_IR[3:0];
  assign w_rs_addr = w_accept ? bus.in_IR[11:8]  : r_sh_IR[11:8];
  // {is_DPI, is_DPIS, is_DPRS, is_LSHSBSO, is_BL, is_pass_thru}
  assign w_cls     = w_accept ? {bus.in_flags[7:5], bus.in_flags[2:0]}
                              : {r_sh_flags[7:5],   r_sh_flags[2:0]};

  assign w_is_dp   = |w_cls[5:3];
  assign w_is_mov  = (w_opc == 4'b1101) || (w_opc == 4'b1111);
  assign w_need_rn = !w_cls[1] && !w_cls[0] && !(SKIP_RN_MOV && w_is_dp && w_is_mov);
  assign w_need_rm = w_cls[4] | w_cls[3] | w_cls[2] | w_cls[0];
  assign w_need_rs = w_cls[3];

  // Next state, pending-capture tag and next RF request.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = P_NONE;
    w_ren_nxt   = 1'b0;
    w_raddr_nxt = r_rf_raddr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_need_rn)      w_state_nxt = S_RN;
          else if (w_need_rm) w_state_nxt = S_RM;
          else if (w_need_rs) w_state_nxt = S_RS;
          else                w_state_nxt = S_OUT;
        end
      end
      S_RN: begin
        if (bus.rf_gnt) begin
          w_pend_nxt = P_RN;
          if (w_need_rm)      w_state_nxt = S_RM;
          else if (w_need_rs) w_state_nxt = S_RS;
          else                w_state_nxt = S_DRAIN;
        end
      end
      S_RM: begin
        if (bus.rf_gnt) begin
          w_pend_nxt  = P_RM;
          w_state_nxt = w_need_rs ? S_RS : S_DRAIN;
        end
      end
      S_RS: begin
        if (bus.rf_gnt) begin
          w_pend_nxt  = P_RS;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: w_state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_pend_nxt  = P_NONE;
    end
    case (w_state_nxt)
      S_RN:    begin w_ren_nxt = 1'b1; w_raddr_nxt = w_rn_addr; end
      S_RM:    begin w_ren_nxt = 1'b1; w_raddr_nxt = w_rm_addr; end
      S_RS:    begin w_ren_nxt = 1'b1; w_raddr_nxt = w_rs_addr; end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= P_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Registered outputs; RF data lands the cycle after its grant, overlapping the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_rf_ren      <= 1'b0;
      r_rf_raddr    <= '0;
      r_sh_IR       <= '0;
      r_sh_flags    <= '0;
      r_sh_Rm_data  <= '0;
      r_sh_Rs_LSB   <= '0;
      r_out_Rn_data <= '0;
    end else begin
      r_out_valid <= (w_state_nxt == S_OUT);
      r_rf_ren    <= w_ren_nxt;
      r_rf_raddr  <= w_raddr_nxt;
      if (w_accept) begin
        r_sh_IR    <= bus.in_IR;
        r_sh_flags <= bus.in_flags;
      end
      case (r_pend)
        P_RN:    r_out_Rn_data <= bus.rf_rdata;
        P_RM:    r_sh_Rm_data  <= bus.rf_rdata;
        P_RS:    r_sh_Rs_LSB   <= bus.rf_rdata[7:0];
        default: ;
      endcase
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.rf_ren      = r_rf_ren;
  assign bus.rf_raddr    = r_rf_raddr;
  assign bus.sh_IR       = r_sh_IR;
  assign bus.sh_flags    = r_sh_flags;
  assign bus.sh_Rm_data  = r_sh_Rm_data;
  assign bus.sh_Rs_LSB   = r_sh_Rs_LSB;
  assign bus.out_Rn_data = r_out_Rn_data;

  // A stalled request must keep its address; a stalled handoff must keep its payload.
  a_raddr_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.rf_ren && !bus.rf_gnt) |=> $stable(bus.rf_raddr));
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      $stable({bus.sh_IR, bus.sh_flags, bus.sh_Rm_data, bus.sh_Rs_LSB, bus.out_Rn_data}));

endmodule

// File: tb/tb_addr_mode1_operand_seq.sv
// Self-checking bench for addr_mode1_operand_seq: table of instructions driven
// through a scoreboard, plus hand sequences for flush and mid-operation reset.
module tb_addr_mode1_operand_seq;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  addr_mode1_operand_seq_if bus();

  addr_mode1_operand_seq #(.SKIP_RN_MOV(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [7:0]  flags;
    int          hold;      // cycles out_ready is held low after out_valid
    int          stall_at;  // grant index at which rf_gnt is withheld (-1 none)
    int          stall_n;
    int          mut_at;    // rewrite Rm in the RF after this many grants (-1 none)
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [7:0]  flags;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [7:0]  rs;
  } exp_t;

  logic [31:0] rf [16];
  exp_t        sb [$];
  logic [31:0] m_rn, m_rm;
  logic [7:0]  m_rs;
  int          n_pass = 0;
  int          n_total = 0;

  // Register file model: data returns the cycle after a granted read.
  always @(posedge clk) begin
    if (rst) bus.rf_rdata <= '0;
    else if (bus.rf_ren && bus.rf_gnt) bus.rf_rdata <= rf[bus.rf_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // {need_rn, need_rm, need_rs}; cls = {DPI, DPIS, DPRS, LSHSBSO, BL, pass_thru}
  function automatic logic [2:0] need_of(input logic [3:0] opc, input logic [5:0] cls);
    logic dp, mov;
    dp  = |cls[5:3];
    mov = (opc == 4'hD) || (opc == 4'hF);
    return {!cls[1] && !cls[0] && !(dp && mov), cls[4] | cls[3] | cls[2] | cls[0], cls[3]};
  endfunction

  task automatic wait_ready(input string nm);
    int w = 0;
    while (!bus.in_ready && w < 20) begin @(negedge clk); w++; end
    chk({nm, "/in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run(input vec_t v);
    logic [2:0]  nd;
    logic [3:0]  ea [$];
    logic [3:0]  got [$];
    logic [31:0] t;
    exp_t        e;
    int          lat, grants, stalls;
    bit          mutated;
    nd = need_of(v.ir[24:21], {v.flags[7:5], v.flags[2:0]});
    if (nd[2]) ea.push_back(v.ir[19:16]);
    if (nd[1]) ea.push_back(v.ir[3:0]);
    if (nd[0]) ea.push_back(v.ir[11:8]);
    wait_ready(v.name);
    if (nd[2]) m_rn = rf[v.ir[19:16]];
    if (nd[1]) m_rm = rf[v.ir[3:0]];
    if (nd[0]) begin t = rf[v.ir[11:8]]; m_rs = t[7:0]; end
    sb.push_back('{v.ir, v.flags, m_rn, m_rm, m_rs});
    bus.in_valid = 1'b1;
    bus.in_IR    = v.ir;
    bus.in_flags = v.flags;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_IR    = $urandom;
    bus.in_flags = 8'($urandom);
    grants = 0; stalls = 0; mutated = 0;
    while (!bus.out_valid && lat < 60) begin
      bus.rf_gnt = 1'b1;
      if (bus.rf_ren) begin
        if (grants == v.stall_at && stalls < v.stall_n) begin
          bus.rf_gnt = 1'b0;
          stalls++;
          if (grants < ea.size()) chk({v.name, "/stall_addr"}, 32'(bus.rf_raddr), 32'(ea[grants]));
        end else begin
          got.push_back(bus.rf_raddr);
          grants++;
        end
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!mutated && v.mut_at >= 0 && grants == v.mut_at) begin
        rf[v.ir[3:0]] = ~rf[v.ir[3:0]];
        mutated = 1;
      end
    end
    bus.rf_gnt = 1'b1;
    chk({v.name, "/latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, "/nreads"}, 32'(got.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size(); i++)
      if (i < got.size()) chk($sformatf("%s/raddr%0d", v.name, i), 32'(got[i]), 32'(ea[i]));
    if (sb.size() == 0) chk({v.name, "/sb_empty"}, 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      chk({v.name, "/sh_IR"},     bus.sh_IR,              e.ir);
      chk({v.name, "/sh_flags"},  32'(bus.sh_flags),      32'(e.flags));
      chk({v.name, "/Rn"},        bus.out_Rn_data,        e.rn);
      chk({v.name, "/Rm"},        bus.sh_Rm_data,         e.rm);
      chk({v.name, "/Rs_LSB"},    32'(bus.sh_Rs_LSB),     32'(e.rs));
      if (v.hold > 0) begin
        repeat (v.hold) @(negedge clk);
        chk({v.name, "/hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({v.name, "/hold_IR"},    bus.sh_IR,          e.ir);
        chk({v.name, "/hold_Rm"},    bus.sh_Rm_data,     e.rm);
        chk({v.name, "/hold_Rn"},    bus.out_Rn_data,    e.rn);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({v.name, "/done_valid"}, 32'(bus.out_valid), 32'd0);
    chk({v.name, "/done_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  vec_t vecs [9];
  vec_t v;
  bit   ov_seen;

  initial begin
    vecs[0] = '{"DPRS_ADD",  32'hE0810312, 8'h20, 0, -1, 0, -1, 5};
    vecs[1] = '{"MOV_imm",   32'hE3A000FF, 8'h80, 5, -1, 0, -1, 1};
    vecs[2] = '{"BL",        32'hEB000010, 8'h02, 0, -1, 0, -1, 1};
    vecs[3] = '{"LDRH_stall",32'hE19400B5, 8'h04, 0,  1, 3, -1, 7};
    vecs[4] = '{"DPIS_mut",  32'hE0860107, 8'h40, 0, -1, 0,  2, 4};
    vecs[5] = '{"MVN_reg",   32'hE1E91008, 8'h40, 0, -1, 0, -1, 3};
    vecs[6] = '{"pass_thru", 32'hE12FFF1E, 8'h01, 2, -1, 0, -1, 3};
    vecs[7] = '{"LDR_pc",    32'hE59F0004, 8'h10, 0, -1, 0, -1, 3};
    vecs[8] = '{"MOV_rsh",   32'hE1A00312, 8'h20, 0,  0, 1, -1, 5};

    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    m_rn = '0; m_rm = '0; m_rs = '0;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_IR = '0; bus.in_flags = '0;
    bus.rf_gnt = 1'b1; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst/in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst/rf_ren",    32'(bus.rf_ren),    32'd0);
    chk("rst/sh_IR",     bus.sh_IR,          32'd0);
    chk("rst/Rn",        bus.out_Rn_data,    32'd0);
    rst = 1'b0;
    #1;
    chk("rst/in_ready_after", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 9; i++) run(vecs[i]);

    // flush while idle: blocks acceptance for that cycle only
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("idle_flush/in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("idle_flush/in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("idle_flush/rf_ren",         32'(bus.rf_ren),   32'd0);

    // flush in RM with Rn already granted
    @(negedge clk);
    wait_ready("flush");
    bus.in_valid = 1'b1; bus.in_IR = 32'hE0810312; bus.in_flags = 8'h20;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("flush/rn_addr", 32'(bus.rf_raddr), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("flush/rm_addr", 32'(bus.rf_raddr), 32'd2);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush/in_ready",  32'(bus.in_ready),  32'd1);
    chk("flush/out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush/rf_ren",    32'(bus.rf_ren),    32'd0);
    ov_seen = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.out_valid) ov_seen = 1'b1; end
    chk("flush/no_out_valid", 32'(ov_seen), 32'd0);

    // next instruction after the flush completes normally
    v = '{"post_flush", 32'hE0894B1A, 8'h20, 0, -1, 0, -1, 5};
    run(v);

    // reset asserted while in DRAIN
    wait_ready("rst_drain");
    bus.in_valid = 1'b1; bus.in_IR = 32'hE0810312; bus.in_flags = 8'h20;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_drain/drain_ren",   32'(bus.rf_ren),    32'd0);
    chk("rst_drain/drain_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_drain/out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_drain/rf_ren",    32'(bus.rf_ren),    32'd0);
    chk("rst_drain/sh_IR",     bus.sh_IR,          32'd0);
    chk("rst_drain/Rn",        bus.out_Rn_data,    32'd0);
    chk("rst_drain/in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    chk("rst_drain/no_late_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_drain/in_ready_after", 32'(bus.in_ready), 32'd1);
    m_rn = '0; m_rm = '0; m_rs = '0;

    // zero-read instruction after reset exposes the cleared operand registers
    run(vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
